// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared types and constants for the accumulator CPU core
// Purpose: opcode encoding, controller state encoding and opcode field width.
// Ports: none (package).
package acc_cpu_pkg;

  localparam int OPC_WIDTH = 3;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC_RD = 3'd3,
    S_EXEC_WR = 3'd4,
    S_HALT    = 3'd5
  } state_t;

endpackage

// File: rtl/acc_cpu_fsm.sv
// rtl/acc_cpu_fsm.sv - controller FSM for the accumulator CPU core
// Purpose: state register, next-state logic and datapath/memory strobes.
// Ports: clk, rst (sync active-low), run, step, mem_ack, ac_zero, opcode (IR opcode)
//        -> ld_ir, ld_ac, ld_pc, inc_pc, skip, mem_req, mem_we, addr_sel,
//           instr_done (registered pulse), halted (registered, sticky).
module acc_cpu_fsm
  import acc_cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    run,
  input  logic    step,
  input  logic    mem_ack,
  input  logic    ac_zero,
  input  opcode_t opcode,
  output logic    ld_ir,
  output logic    ld_ac,
  output logic    ld_pc,
  output logic    inc_pc,
  output logic    skip,
  output logic    mem_req,
  output logic    mem_we,
  output logic    addr_sel,
  output logic    instr_done,
  output logic    halted
);

  state_t state;
  logic   retire;
  logic   exec_state;

  // Memory strobes are pure decodes of the state register, so they hold
  // steady across any number of wait cycles.
  always_comb begin
    exec_state = (state == S_EXEC_RD) || (state == S_EXEC_WR);
    mem_req    = (state == S_FETCH) || exec_state;
    mem_we     = (state == S_EXEC_WR);
    addr_sel   = exec_state;
    ld_ir      = (state == S_FETCH) && mem_ack;
    ld_ac      = (state == S_EXEC_RD) && mem_ack;
    inc_pc     = (state == S_DECODE);
    ld_pc      = inc_pc && (opcode == OP_JMP);
    skip       = inc_pc && (opcode == OP_SKZ) && ac_zero;
    retire     = (inc_pc && ((opcode == OP_SKZ) || (opcode == OP_JMP))) ||
                 (exec_state && mem_ack);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      // HLT counts as a retired instruction as well.
      instr_done <= retire || (inc_pc && (opcode == OP_HLT));
      case (state)
        S_IDLE:   if (run || step) state <= S_FETCH;
        S_FETCH:  if (mem_ack) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_ADD, OP_AND, OP_XOR, OP_LDA: state <= S_EXEC_RD;
            OP_STO: state <= S_EXEC_WR;
            default: state <= run ? S_FETCH : S_IDLE;
          endcase
        end
        S_EXEC_RD, S_EXEC_WR: if (mem_ack) state <= run ? S_FETCH : S_IDLE;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - parametrised multicycle accumulator CPU core
// Purpose: PC/IR/AC registers, ALU and address mux around the FSM controller.
// Ports: clk, rst (sync active-low), run, step; memory port mem_req, mem_we,
//        mem_addr, mem_wdata, mem_rdata, mem_ack; status pc_out, ac_out,
//        halted, instr_done.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  halted,
  output logic                  instr_done
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] ac;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [ADDR_WIDTH-1:0] operand;
  opcode_t               opcode;
  logic ld_ir, ld_ac, ld_pc, inc_pc, skip, addr_sel;

  assign opcode  = opcode_t'(ir[DATA_WIDTH-1 -: OPC_WIDTH]);
  assign operand = ir[ADDR_WIDTH-1:0];

  acc_cpu_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .mem_ack    (mem_ack),
    .ac_zero    (ac == '0),
    .opcode     (opcode),
    .ld_ir      (ld_ir),
    .ld_ac      (ld_ac),
    .ld_pc      (ld_pc),
    .inc_pc     (inc_pc),
    .skip       (skip),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always_comb begin
    case (opcode)
      OP_ADD:  alu_out = ac + mem_rdata;
      OP_AND:  alu_out = ac & mem_rdata;
      OP_XOR:  alu_out = ac ^ mem_rdata;
      default: alu_out = mem_rdata;
    endcase
  end

  // Address is forced to zero whenever no transaction is in flight.
  assign mem_addr  = mem_req ? (addr_sel ? operand : pc) : '0;
  assign mem_wdata = ac;
  assign pc_out    = pc;
  assign ac_out    = ac;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= ADDR_WIDTH'(RESET_PC);
      ir <= '0;
      ac <= '0;
    end else begin
      if (ld_ir) ir <= mem_rdata;
      if (ld_ac) ac <= alu_out;
      // PC wraps naturally at the register width.
      if (ld_pc)       pc <= operand;
      else if (inc_pc) pc <= pc + (skip ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
    end
  end

endmodule
